// File: rtl/alu_pkg.sv
// Shared types for the multi-cycle ALU: operation codes, controller states and op classification.
package alu_pkg;

  typedef enum logic [4:0] {
    OP_ADD   = 5'h00,
    OP_SUB   = 5'h01,
    OP_MUL   = 5'h02,
    OP_DIV   = 5'h03,
    OP_SLL   = 5'h04,
    OP_SRL   = 5'h05,
    OP_ROL   = 5'h06,
    OP_ROR   = 5'h07,
    OP_AND   = 5'h08,
    OP_OR    = 5'h09,
    OP_XOR   = 5'h0A,
    OP_NOR   = 5'h0B,
    OP_NAND  = 5'h0C,
    OP_SLTU  = 5'h0D,
    OP_SLT   = 5'h0E,
    OP_SRA   = 5'h0F,
    OP_SEXTB = 5'h10,
    OP_SEXTH = 5'h11,
    OP_ZEXTB = 5'h12,
    OP_ZEXTH = 5'h13,
    OP_REM   = 5'h14,
    OP_DIVU  = 5'h15,
    OP_REMU  = 5'h16,
    OP_MULHU = 5'h17
  } alu_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXEC,
    ST_DIV_ITER,
    ST_DIV_FIX,
    ST_DONE
  } state_e;

  function automatic logic is_div(input alu_op_e op);
    return op inside {OP_DIV, OP_REM, OP_DIVU, OP_REMU};
  endfunction

  function automatic logic is_signed_div(input alu_op_e op);
    return op inside {OP_DIV, OP_REM};
  endfunction

endpackage

// File: rtl/alu_divider.sv
// Restoring unsigned divider: one quotient bit per cycle, WIDTH cycles from start (start cycle included).
module alu_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CW = $clog2(WIDTH);

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
  logic [WIDTH-1:0] quo_src, rem_src, dvs_src;
  logic [WIDTH:0]   shifted, trial;

  // The first iteration runs on the start cycle directly from the input operands.
  always_comb begin
    quo_src = start ? dividend : quo_q;
    rem_src = start ? '0 : rem_q;
    dvs_src = start ? divisor : dvs_q;
    shifted = {rem_src, quo_src[WIDTH-1]};
    trial   = shifted - {1'b0, dvs_src};
    // NOTE: every _d takes its _q value first so no path through this block infers a latch.
    cnt_d = cnt_q;
    quo_d = quo_q;
    rem_d = rem_q;
    dvs_d = dvs_q;
    if (start || cnt_q != '0) begin
      dvs_d = dvs_src;
      rem_d = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
      quo_d = {quo_src[WIDTH-2:0], ~trial[WIDTH]};
      cnt_d = start ? CW'(WIDTH - 1) : cnt_q - 1'b1;
    end
  end

  // NOTE: sequential state is written with non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      quo_q <= quo_d;
      rem_q <= rem_d;
      dvs_q <= dvs_d;
    end
  end

  assign busy      = (cnt_q != '0);
  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/alu_mc.sv
// Handshaked multi-cycle ALU. Define ALU_DIV_EN to build the iterative divider; without it
// divide/remainder ops finish on the EXEC path with an all-ones result and dbz set.
module alu_mc
  import alu_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  alu_op_e          op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             ovf,
  output logic             dbz
);

  state_e           state_q, state_d;
  alu_op_e          op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, result_q, result_d;
  logic             zero_q, zero_d, carry_q, carry_d, ovf_q, ovf_d, dbz_q, dbz_d;
  logic             out_valid_q, out_valid_d;
  logic             accept;

  logic [WIDTH-1:0]   ex_res;
  logic               ex_carry, ex_ovf, ex_dbz;
  logic [WIDTH:0]     add_w, sub_w;
  logic [2*WIDTH-1:0] prod, rot_l, rot_r;
  logic [SHW-1:0]     sh;

  assign in_ready = !rst && (state_q == ST_IDLE || (state_q == ST_DONE && out_ready));
  assign accept   = in_valid && in_ready && !flush;

  always_comb begin
    sh    = b_q[SHW-1:0];
    add_w = {1'b0, a_q} + {1'b0, b_q};
    sub_w = {1'b0, a_q} + {1'b0, ~b_q} + {{WIDTH{1'b0}}, 1'b1};
    prod  = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
    rot_l = {a_q, a_q} << sh;
    rot_r = {a_q, a_q} >> sh;
    ex_carry = 1'b0;
    ex_ovf   = 1'b0;
    ex_dbz   = 1'b0;
    case (op_q)
      OP_SUB: begin
        ex_res   = sub_w[WIDTH-1:0];
        ex_carry = sub_w[WIDTH];
        ex_ovf   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (sub_w[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_MUL:   ex_res = prod[WIDTH-1:0];
      OP_MULHU: ex_res = prod[2*WIDTH-1:WIDTH];
      OP_SLL:   ex_res = a_q << sh;
      OP_SRL:   ex_res = a_q >> sh;
      OP_SRA:   ex_res = $signed(a_q) >>> sh;
      OP_ROL:   ex_res = rot_l[2*WIDTH-1:WIDTH];
      OP_ROR:   ex_res = rot_r[WIDTH-1:0];
      OP_AND:   ex_res = a_q & b_q;
      OP_OR:    ex_res = a_q | b_q;
      OP_XOR:   ex_res = a_q ^ b_q;
      OP_NOR:   ex_res = ~(a_q | b_q);
      OP_NAND:  ex_res = ~(a_q & b_q);
      OP_SLTU:  ex_res = {{(WIDTH-1){1'b0}}, a_q < b_q};
      OP_SLT:   ex_res = {{(WIDTH-1){1'b0}}, $signed(a_q) < $signed(b_q)};
      OP_SEXTB: ex_res = {{(WIDTH-8){a_q[7]}}, a_q[7:0]};
      OP_SEXTH: ex_res = {{(WIDTH-16){a_q[15]}}, a_q[15:0]};
      OP_ZEXTB: ex_res = {{(WIDTH-8){1'b0}}, a_q[7:0]};
      OP_ZEXTH: ex_res = {{(WIDTH-16){1'b0}}, a_q[15:0]};
      // Only reachable without the divider: divide ops report unsupported.
      OP_DIV, OP_REM, OP_DIVU, OP_REMU: begin
        ex_res = '1;
        ex_dbz = 1'b1;
      end
      default: begin
        ex_res   = add_w[WIDTH-1:0];
        ex_carry = add_w[WIDTH];
        ex_ovf   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (add_w[WIDTH-1] != a_q[WIDTH-1]);
      end
    endcase
  end

`ifdef ALU_DIV_EN
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  logic             div_start, div_busy, div_special;
  logic [WIDTH-1:0] div_quo, div_rem, dvd_abs, dvs_abs, fx_res;
  logic             fx_ovf, fx_dbz, fx_sgn, fx_rem;

  // Divider sees magnitudes; signs are reapplied from the captured operands in DIV_FIX.
  assign dvd_abs     = (is_signed_div(op) && a[WIDTH-1]) ? -a : a;
  assign dvs_abs     = (is_signed_div(op) && b[WIDTH-1]) ? -b : b;
  assign div_special = (b == '0) || (is_signed_div(op) && a == MIN_VAL && b == '1);
  assign div_start   = accept && is_div(op) && !div_special;

  alu_divider #(.WIDTH(WIDTH)) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .dividend (dvd_abs),
    .divisor  (dvs_abs),
    .busy     (div_busy),
    .quotient (div_quo),
    .remainder(div_rem)
  );

  always_comb begin
    fx_sgn = is_signed_div(op_q);
    fx_rem = op_q inside {OP_REM, OP_REMU};
    fx_ovf = 1'b0;
    fx_dbz = 1'b0;
    if (b_q == '0) begin
      fx_dbz = 1'b1;
      fx_res = fx_rem ? a_q : '1;
    end else if (fx_sgn && a_q == MIN_VAL && b_q == '1) begin
      fx_ovf = 1'b1;
      fx_res = fx_rem ? '0 : MIN_VAL;
    end else if (fx_rem) begin
      fx_res = (fx_sgn && a_q[WIDTH-1]) ? -div_rem : div_rem;
    end else begin
      fx_res = (fx_sgn && (a_q[WIDTH-1] ^ b_q[WIDTH-1])) ? -div_quo : div_quo;
    end
  end
`endif

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    result_d    = result_q;
    zero_d      = zero_q;
    carry_d     = carry_q;
    ovf_d       = ovf_q;
    dbz_d       = dbz_q;
    out_valid_d = out_valid_q;
    if (flush) begin
      state_d     = ST_IDLE;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_EXEC: begin
          state_d     = ST_DONE;
          out_valid_d = 1'b1;
          result_d    = ex_res;
          zero_d      = (ex_res == '0);
          carry_d     = ex_carry;
          ovf_d       = ex_ovf;
          dbz_d       = ex_dbz;
        end
`ifdef ALU_DIV_EN
        ST_DIV_ITER: if (!div_busy) state_d = ST_DIV_FIX;
        ST_DIV_FIX: begin
          state_d     = ST_DONE;
          out_valid_d = 1'b1;
          result_d    = fx_res;
          zero_d      = (fx_res == '0);
          carry_d     = 1'b0;
          ovf_d       = fx_ovf;
          dbz_d       = fx_dbz;
        end
`endif
        ST_DONE: if (out_ready) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
        end
        default: ;
      endcase
      if (accept) begin
        op_d        = op;
        a_d         = a;
        b_d         = b;
        out_valid_d = 1'b0;
        state_d     = ST_EXEC;
`ifdef ALU_DIV_EN
        if (is_div(op)) state_d = div_special ? ST_DIV_FIX : ST_DIV_ITER;
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_ADD;
      a_q         <= '0;
      b_q         <= '0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
      dbz_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      carry_q     <= carry_d;
      ovf_q       <= ovf_d;
      dbz_q       <= dbz_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign carry     = carry_q;
  assign ovf       = ovf_q;
  assign dbz       = dbz_q;

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc: directed corner cases, then random ops against an arithmetic model.
module tb_alu_mc;
  import alu_pkg::*;

  localparam int W = 32;
  localparam longint SMAX = (longint'(1) <<< (W - 1)) - 1;
  localparam longint SMIN = -SMAX - 1;
`ifdef ALU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  typedef struct packed {
    logic [W-1:0] res;
    logic         zero;
    logic         carry;
    logic         ovf;
    logic         dbz;
  } exp_t;

  logic         clk, rst, in_valid, in_ready, flush, out_valid, out_ready;
  logic         zero, carry, ovf, dbz;
  alu_op_e      op;
  logic [W-1:0] a, b, result;

  int           n_tests = 0;
  int           n_fail  = 0;
  exp_t         cur_exp;
  int           cur_lat;
  logic [W-1:0] last_res;

  alu_mc #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op       (op),
    .a        (a),
    .b        (b),
    .flush    (flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .zero     (zero),
    .carry    (carry),
    .ovf      (ovf),
    .dbz      (dbz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model(input logic [4:0] opc, input logic [W-1:0] av, input logic [W-1:0] bv);
    exp_t e;
    longint sa, sb, ss;
    longint unsigned ua, ub;
    int s;
    logic [W-1:0] minv;
    sa   = longint'($signed(av));
    sb   = longint'($signed(bv));
    ua   = 64'(av);
    ub   = 64'(bv);
    s    = int'(bv % W);
    minv = W'(SMIN);
    e    = '0;
    case (opc)
      5'h01: begin
        e.res   = av - bv;
        e.carry = (ua >= ub);
        ss      = sa - sb;
        e.ovf   = (ss > SMAX) || (ss < SMIN);
      end
      5'h02: e.res = W'(ua * ub);
      5'h03, 5'h14, 5'h15, 5'h16: begin
        if (!DIV_EN) begin
          e.res = '1;
          e.dbz = 1'b1;
        end else if (bv == '0) begin
          e.dbz = 1'b1;
          e.res = (opc == 5'h14 || opc == 5'h16) ? av : '1;
        end else if ((opc == 5'h03 || opc == 5'h14) && av == minv && bv == '1) begin
          e.ovf = 1'b1;
          e.res = (opc == 5'h14) ? '0 : minv;
        end else if (opc == 5'h03) e.res = W'(sa / sb);
        else if (opc == 5'h14)     e.res = W'(sa % sb);
        else if (opc == 5'h15)     e.res = W'(ua / ub);
        else                       e.res = W'(ua % ub);
      end
      5'h04: e.res = av << s;
      5'h05: e.res = av >> s;
      5'h06: e.res = (av << s) | (av >> ((W - s) % W));
      5'h07: e.res = (av >> s) | (av << ((W - s) % W));
      5'h08: e.res = av & bv;
      5'h09: e.res = av | bv;
      5'h0A: e.res = av ^ bv;
      5'h0B: e.res = ~(av | bv);
      5'h0C: e.res = ~(av & bv);
      5'h0D: e.res = (ua < ub) ? W'(1) : W'(0);
      5'h0E: e.res = (sa < sb) ? W'(1) : W'(0);
      5'h0F: e.res = W'(sa >>> s);
      5'h10: e.res = W'(longint'($signed(av[7:0])));
      5'h11: e.res = W'(longint'($signed(av[15:0])));
      5'h12: e.res = W'(av[7:0]);
      5'h13: e.res = W'(av[15:0]);
      5'h17: e.res = W'((ua * ub) >> W);
      default: begin
        e.res   = av + bv;
        e.carry = ((ua + ub) >> W) != 0;
        ss      = sa + sb;
        e.ovf   = (ss > SMAX) || (ss < SMIN);
      end
    endcase
    e.zero = (e.res == '0);
    return e;
  endfunction

  function automatic int model_lat(input logic [4:0] opc, input logic [W-1:0] av, input logic [W-1:0] bv);
    bit is_d = opc inside {5'h03, 5'h14, 5'h15, 5'h16};
    bit sgn  = opc inside {5'h03, 5'h14};
    if (!DIV_EN || !is_d) return 2;
    if (bv == '0 || (sgn && av == W'(SMIN) && bv == '1)) return 2;
    return W + 2;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accept edge with inputs scrambled.
  task automatic issue(input logic [4:0] opc, input logic [W-1:0] av, input logic [W-1:0] bv);
    in_valid = 1'b1;
    op       = alu_op_e'(opc);
    a        = av;
    b        = bv;
    #1;
    check("in_ready_at_issue", 64'(in_ready), 64'(1));
    @(posedge clk);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    op        = alu_op_e'(5'($urandom));
    a         = $urandom;
    b         = $urandom;
    cur_exp   = model(opc, av, bv);
    cur_lat   = model_lat(opc, av, bv);
  endtask

  task automatic collect(input string tag, input int hold);
    int edges = 1;
    while (!out_valid && edges < 200) begin
      @(posedge clk);
      @(negedge clk);
      edges++;
    end
    check({tag, "_latency"}, 64'(edges), 64'(cur_lat));
    check({tag, "_result"}, 64'(result), 64'(cur_exp.res));
    check({tag, "_flags"}, 64'({zero, carry, ovf, dbz}),
          64'({cur_exp.zero, cur_exp.carry, cur_exp.ovf, cur_exp.dbz}));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      check({tag, "_hold"}, 64'({out_valid, result, zero, carry, ovf, dbz}),
            64'({1'b1, cur_exp.res, cur_exp.zero, cur_exp.carry, cur_exp.ovf, cur_exp.dbz}));
    end
    last_res = cur_exp.res;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("out_valid_after_consume", 64'(out_valid), 64'(0));
  endtask

  task automatic watch_no_valid(input string tag, input int cycles);
    int rose = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid) rose++;
    end
    check(tag, 64'(rose), 64'(0));
  endtask

  initial begin
    logic [4:0]   r_op;
    logic [W-1:0] r_a, r_b;
    int           flush_wait;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    op = OP_ADD; a = '0; b = '0; last_res = '0;
    flush_wait = DIV_EN ? 9 : 0;
    repeat (2) @(negedge clk);
    check("reset_outputs", 64'({out_valid, in_ready, result, zero, carry, ovf, dbz}), 64'(0));
    rst = 1'b0;
    #1;
    check("in_ready_after_reset", 64'(in_ready), 64'(1));
    @(negedge clk);

    issue(5'h00, 32'h7FFF_FFFF, 32'h1);
    collect("add_ovf", 0);
    check("add_ovf_const", 64'({result, ovf, carry, zero}), 64'({32'h8000_0000, 3'b100}));
    consume();

    issue(5'h01, 32'd5, 32'd5);
    collect("sub_zero", 0);
    check("sub_zero_const", 64'({result, zero, carry}), 64'({32'h0, 2'b11}));
    out_ready = 1'b1;
    issue(5'h0E, 32'hFFFF_FFFF, 32'h1);
    collect("slt_b2b", 0);
    check("slt_b2b_const", 64'(result), 64'(1));
    consume();

    issue(5'h03, 32'hFFFF_FFF9, 32'd2);   collect("div_neg", 0);     consume();
    issue(5'h14, 32'hFFFF_FFF9, 32'd2);   collect("rem_neg", 0);     consume();
    issue(5'h15, 32'd100, 32'd7);         collect("divu", 0);        consume();
    issue(5'h03, 32'h8000_0000, '1);      collect("div_min_m1", 0);  consume();
    issue(5'h15, 32'd9, 32'd0);           collect("divu_by0", 0);    consume();
    issue(5'h16, 32'd9, 32'd0);           collect("remu_by0", 0);    consume();
    issue(5'h04, 32'd1, 32'd33);          collect("sll_mask", 0);
    check("sll_mask_const", 64'(result), 64'(2));
    consume();
    issue(5'h07, 32'd1, 32'd4);           collect("ror_hold", 5);
    check("ror_const", 64'(result), 64'(32'h1000_0000));
    consume();

    for (int i = 0; i < 60; i++) begin
      r_op = 5'($urandom_range(0, 31));
      r_a  = $urandom;
      r_b  = $urandom;
      case ($urandom_range(0, 7))
        0: r_b = '0;
        1: begin r_a = 32'h8000_0000; r_b = '1; end
        2: r_b = W'($urandom_range(1, 40));
        default: ;
      endcase
      issue(r_op, r_a, r_b);
      collect($sformatf("rand%0d_op%0h", i, r_op), 0);
      consume();
    end

    issue(5'h03, 32'd1000, 32'd3);
    repeat (flush_wait) begin
      @(posedge clk);
      @(negedge clk);
    end
    flush = 1'b1; in_valid = 1'b1; op = OP_ADD; a = 32'd1; b = 32'd1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    check("flush_idle", 64'({in_ready, out_valid}), 64'(2'b10));
    check("flush_result_kept", 64'(result), 64'(last_res));
    watch_no_valid("flush_no_result", W + 6);

    flush = 1'b1; in_valid = 1'b1; op = OP_ADD; a = 32'd3; b = 32'd4;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    watch_no_valid("flush_drops_accept", 4);

    issue(5'h00, 32'd1, 32'd2);
    collect("pre_rst_add", 0);
    consume();
    issue(5'h03, 32'd1000, 32'd3);
    repeat (4) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst = 1'b1;
    #1;
    check("rst_mid_div", 64'({out_valid, in_ready, result, zero, carry, ovf, dbz}), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("in_ready_after_rst", 64'(in_ready), 64'(1));
    watch_no_valid("rst_no_partial", W + 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
